// File: rtl/alu16_arbiter_pkg.sv
// alu16_arbiter_pkg: shared state encoding, flag bit positions and datapath width
package alu16_arbiter_pkg;
  localparam int ALU_W = 16;
  localparam int FLG_S = 4;
  localparam int FLG_Z = 3;
  localparam int FLG_C = 2;
  localparam int FLG_P = 1;
  localparam int FLG_V = 0;
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/alu16_arbiter_if.sv
// alu16_arbiter_if: request and response bundle between requesters and the shared alu16 arbiter
interface alu16_arbiter_if #(parameter int NREQ = 4, parameter int IDW = 2);
  logic [NREQ-1:0] req;
  logic [16*NREQ-1:0] req_x;
  logic [16*NREQ-1:0] req_y;
  logic [NREQ-1:0] req_ack;
  logic busy;
  logic rsp_valid;
  logic rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [15:0] rsp_z;
  logic [4:0] rsp_flags;
  modport master (output req, req_x, req_y, rsp_ready, input req_ack, busy, rsp_valid, rsp_id, rsp_z, rsp_flags);
  modport slave (input req, req_x, req_y, rsp_ready, output req_ack, busy, rsp_valid, rsp_id, rsp_z, rsp_flags);
endinterface

// File: rtl/alu16.sv
// alu16: combinational 16-bit adder with {sign, zero, carry, parity, overflow} flags
module alu16
  import alu16_arbiter_pkg::*;
(
  input  logic [ALU_W-1:0] x,
  input  logic [ALU_W-1:0] y,
  output logic [ALU_W-1:0] z,
  output logic [4:0]       flags
);
  logic c;
  assign {c, z} = {1'b0, x} + {1'b0, y};
  always_comb begin
    flags        = '0;
    flags[FLG_S] = z[ALU_W-1];
    flags[FLG_Z] = z == '0;
    flags[FLG_C] = c;
    flags[FLG_P] = ~^z;
    flags[FLG_V] = (x[ALU_W-1] == y[ALU_W-1]) && (z[ALU_W-1] != x[ALU_W-1]);
  end
endmodule

// File: rtl/alu16_arbiter_rr_pick.sv
// alu16_arbiter_rr_pick: round-robin pick starting just after the last-granted requester
module alu16_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  logic [IDW-1:0] j;
  // scan farthest-first so the nearest requester after last overrides
  always_comb begin
    grant = '0;
    idx   = '0;
    j     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = IDW'((int'(last) + k) % NREQ);
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/alu16_arbiter.sv
// alu16_arbiter: round-robin sharing of one alu16 among NREQ requesters, one operation in flight
module alu16_arbiter
  import alu16_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic clk,
  input logic rst_n,
  alu16_arbiter_if.slave bus
);
  state_t state;
  logic [ALU_W-1:0] op_x, op_y, z;
  logic [IDW-1:0] op_id, last, idx;
  logic [NREQ-1:0] grant;
  logic [4:0] flags;
  logic any;
  alu16_arbiter_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req(bus.req), .last(last), .grant(grant), .idx(idx), .any(any)
  );
  alu16 u_alu (.x(op_x), .y(op_y), .z(z), .flags(flags));
  // accept pulse coincides with the cycle whose operands get latched
  assign bus.req_ack = (state == IDLE && rst_n) ? grant : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.busy      <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_z     <= '0;
      bus.rsp_flags <= '0;
      op_x          <= '0;
      op_y          <= '0;
      op_id         <= '0;
      last          <= IDW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: if (any) begin
          op_x     <= bus.req_x[int'(idx)*ALU_W +: ALU_W];
          op_y     <= bus.req_y[int'(idx)*ALU_W +: ALU_W];
          op_id    <= idx;
          bus.busy <= 1'b1;
          state    <= EXEC;
        end
        EXEC: begin
          bus.rsp_z     <= z;
          bus.rsp_flags <= flags;
          bus.rsp_id    <= op_id;
          bus.rsp_valid <= 1'b1;
          last          <= op_id;
          state         <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          bus.rsp_valid <= 1'b0;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
